// File: rtl/price_window_buffer.sv
// ---------------------------------------------------------------------------
// price_window_buffer
//
// Sliding-window sample store that sits in front of the moving-average FSM.
// It takes one price per valid/ready handshake into a DEPTH-entry circular
// buffer. It hands the averager the new price together with the price that
// just left the window, which is zero while the window is still filling.
// It then pulses `start` and waits for `avg_done` before it takes the next
// sample. The downstream rolling sum therefore always subtracts exactly the
// sample that fell out of the window.
//
// Optional feature: define PRICE_WINDOW_FLUSH_EN to add the `flush` input.
// When it is high in IDLE, the window is emptied at the next edge.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous active-high reset
//   price_valid  in   1      upstream price available
//   price_in     in   WIDTH  incoming price
//   price_ready  out  1      block can accept a price this cycle
//   new_price    out  WIDTH  latched accepted price
//   oldest_price out  WIDTH  evicted price (0 while window not full)
//   start        out  1      one-cycle pulse to the averager
//   avg_done     in   1      averager done pulse (only honoured in WAIT)
//   window_full  out  1      count == DEPTH
//   count        out  8      samples held, saturates at DEPTH
//   flush        in   1      window clear request (PRICE_WINDOW_FLUSH_EN only)
// ---------------------------------------------------------------------------
module price_window_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             price_valid,
    input  logic [WIDTH-1:0] price_in,
    output logic             price_ready,
    output logic [WIDTH-1:0] new_price,
    output logic [WIDTH-1:0] oldest_price,
    output logic             start,
    input  logic             avg_done,
    output logic             window_full,
    output logic [7:0]       count
`ifdef PRICE_WINDOW_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [7:0]       DEPTH_CNT = 8'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [1:0]       state_reg, state_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [7:0]       count_reg, count_next;
    logic [WIDTH-1:0] new_price_reg, new_price_next;
    logic [WIDTH-1:0] oldest_price_reg;
    logic             start_reg;

    logic             flush_req;
    logic             accept;
    logic             clear;
    logic             full;

    // Sample storage. It has no reset. Stale contents never reach the
    // outputs because the eviction read is gated by `count`.
    logic [WIDTH-1:0] mem [DEPTH];

`ifdef PRICE_WINDOW_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign full        = (count_reg == DEPTH_CNT);
    // A flush request closes the input, so flush wins over a simultaneous valid.
    assign price_ready = (state_reg == IDLE) && !flush_req;
    assign accept      = price_valid && price_ready;
    assign clear       = (state_reg == IDLE) && flush_req;

    // Control FSM: IDLE -> ISSUE on accept, ISSUE -> WAIT, WAIT -> IDLE on done.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)   state_next = ISSUE;
            ISSUE:                 state_next = WAIT;
            WAIT:    if (avg_done) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Pointer, count and new-price updates.
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        count_next     = count_reg;
        new_price_next = new_price_reg;
        if (clear) begin
            wr_ptr_next    = '0;
            count_next     = '0;
            new_price_next = '0;
        end else if (accept) begin
            wr_ptr_next    = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            count_next     = full ? count_reg : count_reg + 8'd1;
            new_price_next = price_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            new_price_reg    <= '0;
            oldest_price_reg <= '0;
            start_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            new_price_reg <= new_price_next;
            // An accept is exactly the IDLE -> ISSUE transition, so the
            // registered start is high for the whole ISSUE cycle.
            start_reg     <= accept;
            if (clear) begin
                oldest_price_reg <= '0;
            end else if (accept) begin
                // The slot at wr_ptr is read in the same edge that overwrites
                // it, so the old contents are captured first.
                oldest_price_reg <= full ? mem[wr_ptr_reg] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= price_in;
        end
    end

    assign new_price    = new_price_reg;
    assign oldest_price = oldest_price_reg;
    assign start        = start_reg;
    assign window_full  = full;
    assign count        = count_reg;

endmodule

// File: tb/tb_price_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_price_window_buffer
//
// Self-checking bench for price_window_buffer. The reference model is a queue
// that holds the last DEPTH accepted prices. The evicted price is the queue
// head when the queue is already full. Directed scenarios are followed by a
// randomized run with random prices, random idle gaps and random averager
// latency. Define PRICE_WINDOW_FLUSH_EN to include the flush scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_price_window_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 10;
    localparam int PTR_W = 4;

    logic             clk;
    logic             rst;
    logic             price_valid;
    logic [WIDTH-1:0] price_in;
    logic             price_ready;
    logic [WIDTH-1:0] new_price;
    logic [WIDTH-1:0] oldest_price;
    logic             start;
    logic             avg_done;
    logic             window_full;
    logic [7:0]       count;
`ifdef PRICE_WINDOW_FLUSH_EN
    logic             flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the last DEPTH accepted prices, oldest at index 0.
    logic [WIDTH-1:0] win_q[$];
    logic [WIDTH-1:0] exp_new;
    logic [WIDTH-1:0] exp_old;

    price_window_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .price_valid  (price_valid),
        .price_in     (price_in),
        .price_ready  (price_ready),
        .new_price    (new_price),
        .oldest_price (oldest_price),
        .start        (start),
        .avg_done     (avg_done),
        .window_full  (window_full),
        .count        (count)
`ifdef PRICE_WINDOW_FLUSH_EN
        ,
        .flush        (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_count();
        return 8'(win_q.size());
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "_new"},   new_price,    exp_new);
        check_eq({tag, "_old"},   oldest_price, exp_old);
        check_eq({tag, "_count"}, count,        exp_count());
        check_eq({tag, "_full"},  window_full,  (win_q.size() == DEPTH) ? 1 : 0);
    endtask

    task automatic model_clear();
        win_q.delete();
        exp_new = '0;
        exp_old = '0;
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] p);
        exp_old = (win_q.size() == DEPTH) ? win_q[0] : '0;
        exp_new = p;
        win_q.push_back(p);
        if (win_q.size() > DEPTH) void'(win_q.pop_front());
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
        model_clear();
    endtask

    // Present a price and wait (bounded) until it is taken; check the edge it lands on.
    task automatic accept_price(input logic [WIDTH-1:0] p);
        int waited = 0;
        price_valid = 1'b1;
        price_in    = p;
        while (!price_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!price_ready) check_eq("ready_timeout", 0, 1);
        tick();
        price_valid = 1'b0;
        model_accept(p);
        check_eq("start_pulse", start, 1);
        check_eq("ready_busy", price_ready, 0);
        check_outputs("accept");
        $display("txn price=%0d new=%0d old=%0d count=%0d full=%0b",
                 p, new_price, oldest_price, count, window_full);
    endtask

    // From ISSUE: drive the averager side. delay=1 is the standard averager.
    task automatic finish_handshake(input int delay, input bit early_done);
        avg_done = early_done;  // done during ISSUE must be ignored
        tick();
        avg_done = 1'b0;
        check_eq("start_low", start, 0);
        check_eq("wait_ready", price_ready, 0);
        repeat (delay) begin
            tick();
            check_eq("wait_hold", price_ready, 0);
        end
        avg_done = 1'b1;
        tick();
        avg_done = 1'b0;
        check_eq("idle_ready", price_ready, 1);
        check_eq("idle_start", start, 0);
    endtask

    task automatic send(input logic [WIDTH-1:0] p, input int delay);
        accept_price(p);
        finish_handshake(delay, 1'b0);
    endtask

    initial begin
        rst         = 1'b0;
        price_valid = 1'b0;
        price_in    = '0;
        avg_done    = 1'b0;
`ifdef PRICE_WINDOW_FLUSH_EN
        flush       = 1'b0;
`endif
        model_clear();
        #2;

        // Reset state.
        do_reset(2);
        check_eq("rst_start", start, 0);
        check_eq("rst_ready", price_ready, 1);
        check_outputs("rst");
        tick();
        check_eq("rst_idle_start", start, 0);
        check_eq("rst_idle_count", count, 0);

        // Warm-up: nothing is evicted yet.
        send(100, 1);
        send(200, 1);
        send(300, 1);

        // Eviction and wrap-around.
        do_reset(1);
        for (int i = 1; i <= 25; i++) send(WIDTH'(i), 1);

        // Back-pressure: valid held with 7 during WAIT; the averager is 5 cycles late.
        accept_price(6);
        tick();
        check_eq("bp_start_low", start, 0);
        price_valid = 1'b1;
        price_in    = 7;
        repeat (5) begin
            tick();
            check_eq("bp_ready", price_ready, 0);
            check_eq("bp_new_hold", new_price, exp_new);
        end
        avg_done = 1'b1;
        tick();
        avg_done = 1'b0;
        check_eq("bp_idle_ready", price_ready, 1);
        check_eq("bp_no_start_yet", start, 0);
        check_eq("bp_not_taken", new_price, exp_new);
        tick();
        price_valid = 1'b0;
        model_accept(7);
        check_eq("bp_start", start, 1);
        check_outputs("bp");
        $display("txn price=7 new=%0d old=%0d count=%0d (back-pressure)", new_price, oldest_price, count);
        finish_handshake(1, 1'b0);
        repeat (3) begin
            tick();
            check_eq("bp_single_start", start, 0);
            check_eq("bp_count_stable", count, exp_count());
        end

        // Reset in the middle of WAIT after 12 samples.
        do_reset(1);
        for (int i = 0; i < 11; i++) send(WIDTH'(1000 + i), 1);
        accept_price(1011);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check_eq("mid_rst_count", count, 0);
        check_eq("mid_rst_ready", price_ready, 1);
        avg_done = 1'b1;  // late done arriving in IDLE must do nothing
        tick();
        avg_done = 1'b0;
        check_eq("spurious_done_ready", price_ready, 1);
        check_eq("spurious_done_start", start, 0);
        send(50, 1);

`ifdef PRICE_WINDOW_FLUSH_EN
        // Flush together with valid in IDLE: flush wins.
        do_reset(1);
        for (int i = 0; i < 12; i++) send(WIDTH'(500 + i), 1);
        flush       = 1'b1;
        price_valid = 1'b1;
        price_in    = 77;
        #1;
        check_eq("flush_ready", price_ready, 0);
        tick();
        flush       = 1'b0;
        price_valid = 1'b0;
        model_clear();
        check_eq("flush_start", start, 0);
        check_outputs("flush");
        send(9, 1);
`endif

        // Randomized run: random prices, idle gaps, averager latency, early done.
        for (int t = 0; t < 80; t++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                tick();
                check_eq("rnd_idle_ready", price_ready, 1);
                check_eq("rnd_idle_start", start, 0);
            end
            accept_price($urandom);
            finish_handshake(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
